// File: rtl/hart_state_if.sv
// Bundles the hart-control request/response signals between the hart switch and the hart state table.
interface hart_state_if;
    logic        hstart;
    logic [1:0]  hstart_hid;
    logic        hstart_ack;
    logic        id_hkill;
    logic [1:0]  id_set_hid;
    logic        prim_set;
    logic [1:0]  prim_hid;
    logic        ic_miss;
    logic [1:0]  ic_miss_hid;
    logic        i_cache_fin;
    logic        dc_miss;
    logic [1:0]  dc_miss_hid;
    logic        d_cache_fin;
    logic [3:0]  acti_hstate;
    logic [3:0]  prim_hstate;
    logic [3:0]  wait_hstate;
    logic        all_wait;
    logic [1:0]  cnt_hid;
    logic        cnt_clr;
    logic [15:0] cnt_val;

    modport master (
        output hstart, hstart_hid, id_hkill, id_set_hid, prim_set, prim_hid,
               ic_miss, ic_miss_hid, i_cache_fin, dc_miss, dc_miss_hid, d_cache_fin,
               cnt_hid, cnt_clr,
        input  hstart_ack, acti_hstate, prim_hstate, wait_hstate, all_wait, cnt_val
    );

    modport slave (
        input  hstart, hstart_hid, id_hkill, id_set_hid, prim_set, prim_hid,
               ic_miss, ic_miss_hid, i_cache_fin, dc_miss, dc_miss_hid, d_cache_fin,
               cnt_hid, cnt_clr,
        output hstart_ack, acti_hstate, prim_hstate, wait_hstate, all_wait, cnt_val
    );
endinterface

// File: rtl/hart_state_unit.sv
// Per-hart state table, primary-hart register and cache-miss ownership for the 4-hart core.
// Define HSTU_STALL_CNT_EN to add per-hart 16-bit saturating stall counters on cnt_val.
module hart_state_unit (
    input  logic        clk,
    input  logic        rst_n,
    hart_state_if.slave hs
);
    localparam int HART_STATE_W = 4;

    typedef enum logic [1:0] {
        H_IDLE,
        H_ACTIVE,
        H_WAIT_IC,
        H_WAIT_DC
    } hstate_e;

    hstate_e     state_q [HART_STATE_W];
    hstate_e     state_d [HART_STATE_W];
    logic [3:0]  prim_q, prim_d;
    logic        ic_vld_q, ic_vld_d;
    logic [1:0]  ic_hid_q, ic_hid_d;
    logic        dc_vld_q, dc_vld_d;
    logic [1:0]  dc_hid_q, dc_hid_d;
    logic        hstart_ack_q, hstart_ack_d;

    logic [3:0]  busy, acti, waitv;
    logic [3:0]  kill_vec, succ_cand, succ;
    logic        kill_ok, start_ok, ic_take, dc_take;

    always_comb begin
        busy  = '0;
        acti  = '0;
        waitv = '0;
        for (int i = 0; i < HART_STATE_W; i++) begin
            busy[i]  = (state_q[i] != H_IDLE);
            acti[i]  = (state_q[i] == H_ACTIVE);
            waitv[i] = (state_q[i] == H_WAIT_IC) || (state_q[i] == H_WAIT_DC);
        end
    end

    // A kill is only refused when it would take down the last non-idle hart.
    assign kill_vec  = 4'b0001 << hs.id_set_hid;
    assign kill_ok   = hs.id_hkill && ((busy & ~kill_vec) != 4'b0000);
    assign succ_cand = busy & ~kill_vec;
    assign succ      = succ_cand & (~succ_cand + 4'd1);

    assign start_ok = hs.hstart && !busy[hs.hstart_hid]
                   && !(ic_vld_q && (ic_hid_q == hs.hstart_hid))
                   && !(dc_vld_q && (dc_hid_q == hs.hstart_hid))
                   && !(hs.id_hkill && (hs.id_set_hid == hs.hstart_hid));

    // A new miss needs a free channel (or one being released this cycle) and loses to a same-cycle kill.
    assign ic_take = hs.ic_miss && acti[hs.ic_miss_hid]
                  && (!ic_vld_q || hs.i_cache_fin)
                  && !(kill_ok && (hs.id_set_hid == hs.ic_miss_hid));
    assign dc_take = hs.dc_miss && acti[hs.dc_miss_hid]
                  && (!dc_vld_q || hs.d_cache_fin)
                  && !(kill_ok && (hs.id_set_hid == hs.dc_miss_hid))
                  && !(ic_take && (hs.ic_miss_hid == hs.dc_miss_hid));

    always_comb begin
        for (int i = 0; i < HART_STATE_W; i++) begin
            state_d[i] = state_q[i];
        end
        ic_vld_d     = ic_vld_q;
        ic_hid_d     = ic_hid_q;
        dc_vld_d     = dc_vld_q;
        dc_hid_d     = dc_hid_q;
        hstart_ack_d = start_ok;

        // A fin for a hart that was killed meanwhile only releases ownership.
        if (hs.i_cache_fin && ic_vld_q) begin
            ic_vld_d = 1'b0;
            if (state_q[ic_hid_q] == H_WAIT_IC) state_d[ic_hid_q] = H_ACTIVE;
        end
        if (hs.d_cache_fin && dc_vld_q) begin
            dc_vld_d = 1'b0;
            if (state_q[dc_hid_q] == H_WAIT_DC) state_d[dc_hid_q] = H_ACTIVE;
        end
        if (ic_take) begin
            state_d[hs.ic_miss_hid] = H_WAIT_IC;
            ic_vld_d = 1'b1;
            ic_hid_d = hs.ic_miss_hid;
        end
        if (dc_take) begin
            state_d[hs.dc_miss_hid] = H_WAIT_DC;
            dc_vld_d = 1'b1;
            dc_hid_d = hs.dc_miss_hid;
        end
        if (start_ok) state_d[hs.hstart_hid] = H_ACTIVE;
        if (kill_ok)  state_d[hs.id_set_hid] = H_IDLE;
    end

    always_comb begin
        prim_d = prim_q;
        if (kill_ok && ((prim_q & kill_vec) != 4'b0000)) begin
            prim_d = succ;
        end else if (hs.prim_set && busy[hs.prim_hid]
                     && !(kill_ok && (hs.prim_hid == hs.id_set_hid))) begin
            prim_d = 4'b0001 << hs.prim_hid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0] <= H_ACTIVE;
            for (int i = 1; i < HART_STATE_W; i++) begin
                state_q[i] <= H_IDLE;
            end
            prim_q       <= 4'b0001;
            ic_vld_q     <= 1'b0;
            ic_hid_q     <= 2'd0;
            dc_vld_q     <= 1'b0;
            dc_hid_q     <= 2'd0;
            hstart_ack_q <= 1'b0;
        end else begin
            for (int i = 0; i < HART_STATE_W; i++) begin
                state_q[i] <= state_d[i];
            end
            prim_q       <= prim_d;
            ic_vld_q     <= ic_vld_d;
            ic_hid_q     <= ic_hid_d;
            dc_vld_q     <= dc_vld_d;
            dc_hid_q     <= dc_hid_d;
            hstart_ack_q <= hstart_ack_d;
        end
    end

    assign hs.acti_hstate = acti;
    assign hs.prim_hstate = prim_q;
    assign hs.wait_hstate = waitv;
    assign hs.all_wait    = (acti == 4'b0000) && (waitv != 4'b0000);
    assign hs.hstart_ack  = hstart_ack_q;

`ifdef HSTU_STALL_CNT_EN
    logic [15:0] cnt_q [HART_STATE_W];
    logic [15:0] cnt_d [HART_STATE_W];
    logic [15:0] cnt_val_q, cnt_val_d;

    always_comb begin
        for (int i = 0; i < HART_STATE_W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (hs.cnt_clr) begin
                cnt_d[i] = 16'h0000;
            end else if (waitv[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
        cnt_val_d = cnt_q[hs.cnt_hid];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HART_STATE_W; i++) begin
                cnt_q[i] <= 16'h0000;
            end
            cnt_val_q <= 16'h0000;
        end else begin
            for (int i = 0; i < HART_STATE_W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            cnt_val_q <= cnt_val_d;
        end
    end

    assign hs.cnt_val = cnt_val_q;
`else
    logic cnt_unused;
    assign cnt_unused = ^{hs.cnt_clr, hs.cnt_hid};
    assign hs.cnt_val = 16'h0000;
`endif
endmodule
